// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan engine: default 640x480 timing, pattern
// mode encodings, RGB565 pixel type and the colour-bar palette.
package vga_pkg;

  localparam int PIX_W = 16;
  typedef logic [PIX_W-1:0] pix_t;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  typedef enum logic [1:0] {
    MODE_BLACK  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_GRID   = 2'd2,
    MODE_STREAM = 2'd3
  } mode_e;

  localparam pix_t BAR_WHITE   = 16'hFFFF;
  localparam pix_t BAR_YELLOW  = 16'hFFE0;
  localparam pix_t BAR_CYAN    = 16'h07FF;
  localparam pix_t BAR_GREEN   = 16'h07E0;
  localparam pix_t BAR_MAGENTA = 16'hF81F;
  localparam pix_t BAR_RED     = 16'hF800;
  localparam pix_t BAR_BLUE    = 16'h001F;
  localparam pix_t BAR_BLACK   = 16'h0000;

  // Bars run left to right in this order.
  function automatic pix_t bar_color(input logic [2:0] idx);
    pix_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational pixel source: selects black, colour bars, grid or the
// (already underrun-resolved) stream pixel according to the latched mode.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int XW       = $clog2(DEF_H_ACTIVE),
  parameter int YW       = $clog2(DEF_V_ACTIVE)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar_idx,
  input  mode_e         mode,
  input  pix_t          fg_color,
  input  pix_t          stream_pix,
  output pix_t          pix
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic grid_hit;

  // Grid lines every 16 pixels plus a closing border on the last column/row.
  assign grid_hit = (x[3:0] == 4'd0) || (y[3:0] == 4'd0) ||
                    (x == X_LAST) || (y == Y_LAST);

  always_comb begin
    pix = '0;
    case (mode)
      MODE_BLACK:  pix = '0;
      MODE_BARS:   pix = bar_color(bar_idx);
      MODE_GRID:   pix = grid_hit ? fg_color : '0;
      MODE_STREAM: pix = stream_pix;
      default:     pix = '0;
    endcase
  end

endmodule

// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan engine: raster counters, sync/DE generation, stream
// handshake with sticky underrun flag, and registered video outputs.
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter pix_t UNDER_COLOR = 16'hF81F
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic [1:0]                  MODE,
  input  logic [PIX_W-1:0]            FG_COLOR,
  input  logic [PIX_W-1:0]            PIX_DATA,
  input  logic                        PIX_VALID,
  output logic                        PIX_READY,
  input  logic                        CLR_UNDER,
  output logic                        UNDERRUN,
  output logic                        FRAME_START,
  output logic                        VGA_HSYNC,
  output logic                        VGA_VSYNC,
  output logic                        VGA_DE,
  output logic [PIX_W-1:0]            VGAD,
  output logic [$clog2(H_ACTIVE)-1:0] PIX_X,
  output logic [$clog2(V_ACTIVE)-1:0] PIX_Y
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BCW     = $clog2(BAR_W + 1);

  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_E  = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_ACT_BEG = HCW'(H_SYNC + H_BACK);
  localparam logic [HCW-1:0] H_ACT_END = HCW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_SYNC_E  = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_ACT_BEG = VCW'(V_SYNC + V_BACK);
  localparam logic [VCW-1:0] V_ACT_END = VCW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [BCW-1:0] BAR_LAST  = BCW'(BAR_W - 1);

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  mode_e          mode_q, mode_d;
  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  pix_t           vgad_q, vgad_d;
  logic [XW-1:0]  pix_x_q, pix_x_d;
  logic [YW-1:0]  pix_y_q, pix_y_d;
  logic           frame_start_q, frame_start_d;
  logic           underrun_q, underrun_d;

  logic           h_act, v_act, active, frame_origin;
  logic [XW-1:0]  x_cur;
  logic [YW-1:0]  y_cur;
  logic           pix_ready;
  logic           under_set;
  pix_t           stream_pix;
  pix_t           pattern_pix;

  assign h_act        = (hc_q >= H_ACT_BEG) && (hc_q < H_ACT_END);
  assign v_act        = (vc_q >= V_ACT_BEG) && (vc_q < V_ACT_END);
  assign active       = h_act && v_act;
  assign frame_origin = (hc_q == '0) && (vc_q == '0);
  assign x_cur        = XW'(hc_q - H_ACT_BEG);
  assign y_cur        = YW'(vc_q - V_ACT_BEG);

  // Stream handshake is combinational so the pixel accepted this cycle is
  // the one registered onto VGAD at the next edge.
  assign pix_ready  = active && (mode_q == MODE_STREAM);
  assign under_set  = pix_ready && !PIX_VALID;
  assign stream_pix = PIX_VALID ? PIX_DATA : UNDER_COLOR;
  assign PIX_READY  = pix_ready;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  // Mode is frozen for the whole frame once captured at the raster origin.
  always_comb begin
    mode_d = frame_origin ? mode_e'(MODE) : mode_q;
  end

  // Bar index advances every BAR_W active pixels; cleared during blanking.
  always_comb begin
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (h_act) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern (
    .x          (x_cur),
    .y          (y_cur),
    .bar_idx    (bar_idx_q),
    .mode       (mode_q),
    .fg_color   (FG_COLOR),
    .stream_pix (stream_pix),
    .pix        (pattern_pix)
  );

  always_comb begin
    hsync_d       = (hc_q < H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (vc_q < V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
    de_d          = active;
    vgad_d        = active ? pattern_pix : '0;
    pix_x_d       = active ? x_cur : '0;
    pix_y_d       = active ? y_cur : '0;
    frame_start_d = frame_origin;
    // A new underrun wins over a simultaneous clear.
    underrun_d    = under_set || (underrun_q && !CLR_UNDER);
  end

  // Counter state -> registered pins (one cycle of latency).
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hc_q          <= '0;
      vc_q          <= '0;
      mode_q        <= MODE_BLACK;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      vgad_q        <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_q        <= mode_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vgad_q        <= vgad_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign VGA_HSYNC   = hsync_q;
  assign VGA_VSYNC   = vsync_q;
  assign VGA_DE      = de_q;
  assign VGAD        = vgad_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign FRAME_START = frame_start_q;
  assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboard bench for vga_scan_engine on a reduced timing set: the driver
// pushes expected outputs from a raster-position model, a monitor pops them.
module tb_vga_scan_engine;

  localparam int HS = 4, HB = 3, HA = 32, HF = 2;
  localparam int VS = 2, VB = 2, VA = 20, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam logic [15:0] UNDER = 16'hF81F;
  localparam int XW = $clog2(HA);
  localparam int YW = $clog2(VA);

  logic          CLOCK, RESET;
  logic [1:0]    MODE;
  logic [15:0]   FG_COLOR, PIX_DATA, VGAD;
  logic          PIX_VALID, PIX_READY, CLR_UNDER, UNDERRUN, FRAME_START;
  logic          VGA_HSYNC, VGA_VSYNC, VGA_DE;
  logic [XW-1:0] PIX_X;
  logic [YW-1:0] PIX_Y;

  vga_scan_engine #(
    .H_SYNC (HS), .H_BACK (HB), .H_ACTIVE (HA), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .UNDER_COLOR (UNDER)
  ) dut (
    .CLOCK (CLOCK), .RESET (RESET), .MODE (MODE), .FG_COLOR (FG_COLOR),
    .PIX_DATA (PIX_DATA), .PIX_VALID (PIX_VALID), .PIX_READY (PIX_READY),
    .CLR_UNDER (CLR_UNDER), .UNDERRUN (UNDERRUN), .FRAME_START (FRAME_START),
    .VGA_HSYNC (VGA_HSYNC), .VGA_VSYNC (VGA_VSYNC), .VGA_DE (VGA_DE),
    .VGAD (VGAD), .PIX_X (PIX_X), .PIX_Y (PIX_Y)
  );

  typedef struct {
    logic hs, vs, de, fs, und, rdy;
    logic [15:0] pix;
    int x, y, k;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic mon_ok;
  int total = 0;
  int bad = 0;
  int pos = 0;
  int cnt = 0;
  logic [1:0] frame_mode = 2'd0;
  logic und = 1'b0;
  logic [15:0] fg = 16'h0;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic int hpos(input int p); return p % HT; endfunction
  function automatic int vpos(input int p); return (p / HT) % VT; endfunction
  function automatic int px(input int p); return hpos(p) - HA0; endfunction
  function automatic int py(input int p); return vpos(p) - VA0; endfunction
  function automatic bit act(input int p);
    return px(p) >= 0 && px(p) < HA && py(p) >= 0 && py(p) < VA;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, {VGA_HSYNC, VGA_VSYNC, VGA_DE, VGAD, 2'b0, PIX_X, 2'b0, PIX_Y, FRAME_START, UNDERRUN, PIX_READY},
        {~HPOL, ~VPOL, 1'b0, 16'h0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0});
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic [1:0] m, input logic v, input logic c);
    exp_t e;
    bit a, strm;
    MODE = m; PIX_VALID = v; CLR_UNDER = c; PIX_DATA = cnt[15:0]; FG_COLOR = fg;
    if (pos % FT == 0) frame_mode = m;
    a = act(pos);
    strm = a && frame_mode == 2'd3;
    e.hs = (hpos(pos) < HS) ? HPOL : ~HPOL;
    e.vs = (vpos(pos) < VS) ? VPOL : ~VPOL;
    e.de = a;
    e.x = px(pos);
    e.y = py(pos);
    e.fs = (pos % FT == 0);
    e.pix = 16'h0;
    if (a) begin
      case (frame_mode)
        2'd1: e.pix = bars[px(pos) / (HA / 8)];
        2'd2: e.pix = (px(pos) % 16 == 0 || py(pos) % 16 == 0 ||
                       px(pos) == HA - 1 || py(pos) == VA - 1) ? fg : 16'h0;
        2'd3: e.pix = v ? cnt[15:0] : UNDER;
        default: e.pix = 16'h0;
      endcase
    end
    if (strm && !v) und = 1'b1;
    else if (c) und = 1'b0;
    e.und = und;
    if (strm && v) cnt++;
    e.rdy = act(pos + 1) && ((pos + 1) % FT != 0) && frame_mode == 2'd3;
    e.k = pos;
    q.push_back(e);
    pos++;
    @(negedge CLOCK);
  endtask

  // vmode: 0 valid always, 1 random drops/clears, 2 scripted drops/clears.
  task automatic frame(input logic [1:0] m, input int vmode);
    for (int i = 0; i < FT; i++) begin
      logic v, c;
      int ai;
      v = 1'b1;
      c = 1'b0;
      ai = py(pos) * HA + px(pos);
      if (vmode == 1) begin
        v = ($urandom_range(7) != 0);
        c = ($urandom_range(15) == 0);
      end else if (vmode == 2 && act(pos)) begin
        v = !(ai == 40 || ai == 41 || ai == 42 || ai == 200);
        c = (ai == 120 || ai == 200);
      end
      step(m, v, c);
    end
  endtask

  always @(posedge CLOCK) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_ok = (VGA_HSYNC === mon_e.hs) && (VGA_VSYNC === mon_e.vs) &&
               (VGA_DE === mon_e.de) && (VGAD === mon_e.pix) &&
               (FRAME_START === mon_e.fs) && (UNDERRUN === mon_e.und) &&
               (PIX_READY === mon_e.rdy);
      if (mon_e.de) mon_ok = mon_ok && (int'(PIX_X) == mon_e.x) && (int'(PIX_Y) == mon_e.y);
      total++;
      if (!mon_ok) begin
        bad++;
        $display("FAIL out k=%0d got hs=%b vs=%b de=%b pix=%h x=%0d y=%0d fs=%b und=%b rdy=%b expected hs=%b vs=%b de=%b pix=%h x=%0d y=%0d fs=%b und=%b rdy=%b",
                 mon_e.k, VGA_HSYNC, VGA_VSYNC, VGA_DE, VGAD, PIX_X, PIX_Y, FRAME_START, UNDERRUN, PIX_READY,
                 mon_e.hs, mon_e.vs, mon_e.de, mon_e.pix, mon_e.x, mon_e.y, mon_e.fs, mon_e.und, mon_e.rdy);
      end
    end
  end

  initial begin
    RESET = 1'b0; MODE = 2'd0; FG_COLOR = 16'h0; PIX_DATA = 16'h0;
    PIX_VALID = 1'b0; CLR_UNDER = 1'b0;
    #1 RESET = 1'b1;
    #1 check_reset("rst_init");
    @(posedge CLOCK); #1 check_reset("rst_edge");
    @(negedge CLOCK);
    RESET = 1'b0;
    pos = 0;

    frame(2'd0, 0);
    frame(2'd0, 0);
    frame(2'd1, 0);
    fg = 16'h07E0;
    frame(2'd2, 0);
    fg = 16'($urandom);
    frame(2'd2, 0);
    cnt = 0;
    frame(2'd3, 0);
    frame(2'd3, 2);
    frame(2'd3, 1);

    // Mode changes mid-frame must wait for the next frame origin.
    for (int i = 0; i < FT; i++) step((i < FT / 2) ? 2'd1 : 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 7 * HT + HA0 + 10; i++) step((i == 0) ? 2'd2 : 2'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an active line.
    #3 RESET = 1'b1;
    #1 check_reset("rst_async");
    @(posedge CLOCK); #1 check_reset("rst_held");
    @(negedge CLOCK);
    RESET = 1'b0;
    pos = 0;
    und = 1'b0;

    frame(2'd1, 0);
    frame(2'd3, 1);

    @(posedge CLOCK); #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine: generates HSYNC/VSYNC/DE for any timing set, and drives 16-bit RGB565 pixels from one of three internal test patterns or an external ready/valid pixel stream. It sits in the pixel-clock domain, downstream of the PLL's VGA output, and replaces the fixed 640x480 function module for designs that need other resolutions, sync polarities or a frame-buffer stream. Underruns on the stream are flagged, never stalled.

## Interface
- H_SYNC, 96, HSYNC width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, VSYNC width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- HSYNC_POL, 0, asserted level of VGA_HSYNC
- VSYNC_POL, 0, asserted level of VGA_VSYNC
- UNDER_COLOR, 16'hF81F, pixel driven on stream underrun
- CLOCK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- MODE  in  2  0 black, 1 colour bars, 2 grid, 3 stream; sampled at frame start
- FG_COLOR  in  16  grid line colour
- PIX_DATA  in  16  stream pixel, RGB565
- PIX_VALID  in  1  stream pixel valid
- PIX_READY  out  1  engine consumes PIX_DATA this cycle if PIX_VALID
- CLR_UNDER  in  1  clears UNDERRUN
- UNDERRUN  out  1  sticky: stream pixel requested but not valid
- FRAME_START  out  1  one-cycle pulse, first output cycle of a frame
- VGA_HSYNC, VGA_VSYNC  out  1 each  sync outputs
- VGA_DE  out  1  visible-pixel indicator
- VGAD  out  16  RGB565 pixel; 0 when VGA_DE low
- PIX_X, PIX_Y  out  clog2(H_ACTIVE), clog2(V_ACTIVE)  coordinates of pixel on VGAD, valid when VGA_DE

## Operation
- Counters hc 0..H_TOTAL-1, vc 0..V_TOTAL-1 (H_TOTAL = sum of H params, likewise V). hc wraps to 0 at H_TOTAL-1; vc advances on that wrap and wraps at V_TOTAL-1.
- Regions per counter: sync [0, SYNC), back porch, active [SYNC+BACK, SYNC+BACK+ACTIVE), front porch.
- Active pixel = both counters in active region; x = hc-(H_SYNC+H_BACK), y = vc-(V_SYNC+V_BACK).
- Mode register loads MODE when hc=0 and vc=0; mid-frame MODE changes are ignored until the next frame.
- Mode 1: 8 equal vertical bars, H_ACTIVE/8 wide, left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a per-line width counter; no divider.
- Mode 2: FG_COLOR where x[3:0]==0 or y[3:0]==0 or x==H_ACTIVE-1 or y==V_ACTIVE-1; else 0000.
- Mode 3: PIX_READY is combinational = active pixel and mode==3. On READY&VALID, PIX_DATA is shown. On READY&!VALID, UNDER_COLOR is shown and UNDERRUN is set. PIX_VALID outside READY is ignored.
- UNDERRUN: set has priority over CLR_UNDER in the same cycle.
- Reset, asynchronous: counters, mode register (0), VGAD, VGA_DE, PIX_X/Y, FRAME_START, UNDERRUN all 0. VGA_HSYNC = ~HSYNC_POL, VGA_VSYNC = ~VSYNC_POL.
- RESET asserted mid-frame aborts the frame. After release, scanning restarts at hc=vc=0 with a fresh FRAME_START.

## Timing
- All video outputs are registered: one-cycle latency from counter state to pins. PIX_READY leads VGAD by exactly one cycle.
- First rising edge after reset release drives counter state (0,0): VGA_HSYNC and VGA_VSYNC asserted, FRAME_START=1 on that output cycle.
- 640x480 defaults: line 800 clocks, frame 420000 clocks. The first VGA_DE of a frame appears at output cycle 35*800+144 after FRAME_START.
- UNDERRUN rises in the same cycle the UNDER_COLOR pixel appears on VGAD.

## Structure
- Package vga_pkg holds:
  - default 640x480 timing constants
  - mode encodings MODE_BLACK/BARS/GRID/STREAM
  - the 8 bar colour constants
  - the RGB565 pixel type width
- One sub-module, vga_pattern: takes x, y, the mode register, FG_COLOR and stream data, and returns the combinational pixel. The top holds the counters, handshake and output registers.

## Test plan
- Defaults, mode 0, 2 frames: HSYNC low 96 of every 800 clocks, VSYNC low 1600 of every 420000 clocks, DE high 640x480 cycles per frame, VGAD=0 throughout.
- Mode 1: line 0 shows FFFF for x 0..79, FFE0 for x 80..159, and so on, with 0000 for x 560..639; PIX_X/PIX_Y match the pixel position.
- Mode 2, FG_COLOR=07E0: VGAD=07E0 at (0,5), (16,5), (639,100), (5,479); VGAD=0000 at (5,5).
- Mode 3, PIX_VALID always 1, PIX_DATA = incrementing counter gated by READY: frame shows values 0..307199 mod 2^16 in raster order; UNDERRUN stays 0.
- Mode 3, PIX_VALID dropped for 3 READY cycles: exactly 3 F81F pixels appear; UNDERRUN stays 1 until CLR_UNDER; a set and a clear in the same cycle leave UNDERRUN at 1.
- MODE 1→2 switched mid-frame, then RESET pulsed mid-line: the pattern changes only at the next FRAME_START; during reset all outputs take their reset values asynchronously, and FRAME_START pulses on the first edge after release.
